dmem_bus_bridge: RTL and testbench
==================================

Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the CPU MEM stage and replaces the single-cycle data memory.
- Converts MEM-stage load/store requests into AXI4-Lite master transactions on an external data bus.
- Returns the raw 32-bit read word to the load data unit.
- Asserts a stall that freezes the whole pipeline (PC, IF/ID, ID/EX, EX/MEM write enables; MEM/WB receives a bubble) until the bus transaction completes.

Parameters:
- ADDR_WIDTH, 32, byte address width of the MEM-stage request and the bus.
- DATA_WIDTH, 32, data width; fixed to 32, with a strobe width of DATA_WIDTH/8.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- mem_r  in  1  MEM-stage load request
- mem_w  in  1  MEM-stage store request
- mem_addr  in  ADDR_WIDTH  byte address (MEM ALU result)
- mem_w_data  in  32  store data
- mem_w_strb  in  4  store byte strobes, pre-aligned to the address
- mem_r_data  out  32  captured read word, full word and unshifted
- stall  out  1  pipeline freeze request
- bus_err  out  1  one-cycle pulse on a SLVERR/DECERR response
- awaddr  out  ADDR_WIDTH, awvalid out 1, awready in 1
- wdata out 32, wstrb out 4, wvalid out 1, wready in 1
- bresp in 2, bvalid in 1, bready out 1
- araddr out ADDR_WIDTH, arvalid out 1, arready in 1
- rdata in 32, rresp in 2, rvalid in 1, rready out 1

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state = IDLE
  - all valid/ready outputs = 0
  - stall = 0, bus_err = 0, mem_r_data = 0
  - addr/data/strb registers = 0
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- stall is combinational: 1 when (state==IDLE and (mem_r or mem_w)), or state is in {WR, WR_RESP, RD_ADDR, RD_DATA}; 0 in DONE.
- Upstream contract: the pipeline holds the MEM-stage request stable while stall=1.
- IDLE:
  - mem_w=1: latch addr, data and strb; raise awvalid and wvalid; go to WR. This holds regardless of mem_r, so a write wins when both are asserted (an illegal combination that must not hang).
  - mem_r=1 only: latch addr; raise arvalid; go to RD_ADDR.
  - Neither: stay in IDLE.
- Bus address is {mem_addr[ADDR_WIDTH-1:2],2'b00}, i.e. word aligned. Byte selection is carried by wstrb on writes and performed downstream on reads.
- WR:
  - AW and W handshake independently. awvalid drops in the cycle after awvalid&awready; wvalid likewise.
  - Two internal flags, aw_done and w_done, record completion.
  - When both are complete (including both completing in the same cycle), raise bready and go to WR_RESP.
  - valid is never dropped before its ready is seen.
- WR_RESP: on bvalid&bready, drop bready. If bresp!=0, pulse bus_err for 1 cycle. Go to DONE.
- RD_ADDR: on arvalid&arready, drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid&rready, drop rready and capture rdata into mem_r_data. If rresp!=0, pulse bus_err. Go to DONE.
- DONE:
  - Exactly 1 cycle with stall=0, so the pipeline advances and MEM/WB samples mem_r_data.
  - Then return to IDLE. The request presented in the cycle after DONE is the next instruction's.
  - A back-to-back memory op therefore costs at least 1 cycle in IDLE+DONE overhead.
- mem_r_data holds its value until the next read capture; writes do not alter it.
- Minimum latency with a zero-wait slave:
  - Read: IDLE→RD_ADDR→RD_DATA→DONE, so stall is high for 3 cycles.
  - Write: IDLE→WR→WR_RESP→DONE, likewise 3 cycles.
- Wait states on any ready or valid simply extend the current state; there is no timeout.
- Reset mid-transaction aborts immediately to IDLE with all valids low. Any resulting slave inconsistency is the system reset's concern.

Decomposition:
- Shared package (SYSTEM_DEF): state encodings (3-bit localparams), the AXI response codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11, and ADDR_WIDTH/DATA_WIDTH defaults.
- There is no sub-module: a single FSM with its registers is sufficient. An optional axi_lite_if bundle can be added later.

Test Plan:
- Zero-wait read: mem_r=1, addr=0x0000_1006, slave rdata=0xA5A5_1234 →
  - araddr=0x0000_1004
  - stall high for exactly 3 cycles
  - mem_r_data=0xA5A5_1234 in the DONE cycle
  - bus_err=0
- Store with skewed handshakes: mem_w=1, addr=0x20, data=0x0000_00FF, strb=4'b0001; wready arrives 4 cycles after awready →
  - wdata/wstrb are held stable until wready
  - bready rises only after both handshakes
  - a single DONE cycle
  - mem_r_data is unchanged
- Simultaneous AW/W ready and wait-stated B: awready=wready=1 in the first WR cycle, bvalid after 5 cycles →
  - WR lasts 1 cycle
  - stall high for 7 cycles total
  - no duplicate AW or W handshake
- Error response: read with rresp=2'b10 → bus_err pulses for 1 cycle in the DONE transition, and rdata is still captured.
- Back-to-back ops and illegal combination:
  - A load immediately followed by a store → two independent transactions, each ending in DONE, with no request re-issued.
  - mem_r=mem_w=1 → only the write is issued.
- Async reset mid-read: assert rst while in RD_DATA, between clock edges →
  - rready, arvalid and stall are 0 immediately
  - state returns to IDLE
  - after rst drops, a new read completes normally.

Source files
------------

// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the MEM-stage to AXI4-Lite data bus bridge.
package dmem_bus_bridge_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  // Bridge FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY is reported to the pipeline as a bus error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_OKAY:                err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge.sv
// Replaces the single-cycle data memory: turns MEM-stage loads and stores
// into AXI4-Lite transactions and freezes the pipeline until they finish.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  // MEM-stage side
  input  logic                    mem_r,
  input  logic                    mem_w,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_w_data,
  input  logic [DATA_WIDTH/8-1:0] mem_w_strb,
  output logic [DATA_WIDTH-1:0]   mem_r_data,
  output logic                    stall,
  output logic                    bus_err,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI4-Lite write response
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  state_t                    state, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                      aw_done, aw_done_d, w_done, w_done_d;
  logic                      bus_err_d;
  logic                      aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0]     req_addr_aligned;
  logic                      unused_addr_lsbs;

  // Byte lanes are selected by wstrb on writes and downstream on reads,
  // so the bus only ever sees word-aligned addresses.
  assign req_addr_aligned = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr_lsbs = ^mem_addr[1:0];

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  assign awaddr     = addr_q;
  assign araddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign mem_r_data = rdata_q;

  // Freeze the pipeline from the cycle a request appears until DONE;
  // DONE itself lets the pipeline advance so MEM/WB can take the result.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:                                      stall = mem_r | mem_w;
        ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA:    stall = 1'b1;
        default:                                      stall = 1'b0;
      endcase
    end
  end

  // Next-state and next-register values for the whole transaction FSM.
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid;
    wvalid_d  = wvalid;
    bready_d  = bready;
    arvalid_d = arvalid;
    rready_d  = rready;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    bus_err_d = 1'b0;
    case (state)
      ST_IDLE: begin
        // A store takes priority so a malformed load+store request
        // still produces exactly one transaction.
        if (mem_w) begin
          addr_d    = req_addr_aligned;
          wdata_d   = mem_w_data;
          wstrb_d   = mem_w_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR;
        end else if (mem_r) begin
          addr_d    = req_addr_aligned;
          arvalid_d = 1'b1;
          state_d   = ST_RD_ADDR;
        end
      end
      ST_WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid && bready) begin
          bready_d  = 1'b0;
          bus_err_d = resp_is_err(bresp);
          state_d   = ST_DONE;
        end
      end
      ST_RD_ADDR: begin
        if (arvalid && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (rvalid && rready) begin
          rready_d  = 1'b0;
          rdata_d   = rdata;
          bus_err_d = resp_is_err(rresp);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transaction straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Handshake flags, request capture and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      bready  <= bready_d;
      arvalid <= arvalid_d;
      rready  <= rready_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
      bus_err <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed table, random ops
// against a transaction-level model, and an asynchronous reset sequence.
module tb_dmem_bus_bridge;

  logic        clk, rst;
  logic        mem_r, mem_w;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic [3:0]  mem_w_strb;
  logic        stall, bus_err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  dmem_bus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_w_strb(mem_w_strb),
    .mem_r_data(mem_r_data), .stall(stall), .bus_err(bus_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // One memory operation plus what the bridge must do with it.
  typedef struct {
    bit          rd, wr;
    logic [31:0] addr, data;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] slv_rdata;
    int          exp_stall;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_baddr;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave configuration (written by the stimulus only).
  int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata, cfg_wdata;
  logic [3:0]  cfg_wstrb;

  // Slave observations (written by the slave only).
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          hold_err = 0, early_b = 0, err_pulses = 0;
  logic [31:0] got_awaddr, got_wdata, got_araddr;
  logic [3:0]  got_wstrb;

  logic [31:0] model_rdata;
  int          exp_pulses = 0;
  vec_t        tbl [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // AXI4-Lite slave with programmable wait states; readies and
  // responses are driven on the falling edge.
  initial begin
    int  aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit  aw_seen, w_seen;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_seen = 0; w_seen = 0;
    forever begin
      @(negedge clk);
      if (bus_err) err_pulses++;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_seen = 0; w_seen = 0;
      end else begin
        if (awvalid) begin
          awready = (aw_wait >= cfg_aw_d);
          if (awready) begin aw_cnt++; got_awaddr = awaddr; aw_seen = 1; end
          aw_wait++;
        end else begin
          awready = 0; aw_wait = 0;
        end
        if (wvalid) begin
          if (wdata !== cfg_wdata || wstrb !== cfg_wstrb) hold_err++;
          wready = (w_wait >= cfg_w_d);
          if (wready) begin w_cnt++; got_wdata = wdata; got_wstrb = wstrb; w_seen = 1; end
          w_wait++;
        end else begin
          wready = 0; w_wait = 0;
        end
        if (bready) begin
          if (b_wait == 0) begin
            if (!aw_seen || !w_seen) early_b++;
            aw_seen = 0; w_seen = 0;
          end
          bvalid = (b_wait >= cfg_b_d);
          bresp  = bvalid ? cfg_resp : 2'b00;
          if (bvalid) b_cnt++;
          b_wait++;
        end else begin
          bvalid = 0; bresp = 0; b_wait = 0;
        end
        if (arvalid) begin
          arready = (ar_wait >= cfg_ar_d);
          if (arready) begin ar_cnt++; got_araddr = araddr; end
          ar_wait++;
        end else begin
          arready = 0; ar_wait = 0;
        end
        if (rready) begin
          rvalid = (r_wait >= cfg_r_d);
          rdata  = rvalid ? cfg_rdata : $urandom;
          rresp  = rvalid ? cfg_resp : 2'b00;
          if (rvalid) r_cnt++;
          r_wait++;
        end else begin
          rvalid = 0; rdata = $urandom; rresp = 0; r_wait = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] data,
                              logic [3:0] strb, int aw_d, int w_d, int b_d, int ar_d,
                              int r_d, logic [1:0] resp, logic [31:0] srd, int es,
                              bit ee, logic [31:0] erd, logic [31:0] eba);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
    v.resp = resp; v.slv_rdata = srd;
    v.exp_stall = es; v.exp_err = ee; v.exp_rdata = erd; v.exp_baddr = eba;
    return v;
  endfunction

  // Transaction-level expectation: one request cycle, then each channel
  // phase costs its wait states plus the handshake cycle.
  function automatic vec_t modelExpect(vec_t v);
    vec_t r = v;
    int   m = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    if (v.wr) begin
      r.exp_stall = 1 + (m + 1) + (v.b_d + 1);
      r.exp_rdata = model_rdata;
    end else begin
      r.exp_stall = 1 + (v.ar_d + 1) + (v.r_d + 1);
      r.exp_rdata = v.slv_rdata;
    end
    r.exp_err   = (v.resp != 2'b00);
    r.exp_baddr = v.addr & 32'hFFFF_FFFC;
    return r;
  endfunction

  // Present one request in the cycle after the previous DONE and run it
  // to completion, checking everything observable in its DONE cycle.
  task automatic applyStimulus(input string tag, input vec_t v);
    int n;
    int aw0, w0, b0, ar0, r0, h0, e0;
    @(posedge clk); #1;
    cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
    cfg_ar_d = v.ar_d; cfg_r_d = v.r_d; cfg_resp = v.resp;
    cfg_rdata = v.slv_rdata; cfg_wdata = v.data; cfg_wstrb = v.strb;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    h0 = hold_err; e0 = early_b;
    mem_r = v.rd; mem_w = v.wr; mem_addr = v.addr;
    mem_w_data = v.data; mem_w_strb = v.strb;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    mem_r = 0; mem_w = 0; mem_addr = $urandom;
    checkOutput({tag, "_stall_cycles"}, n, v.exp_stall);
    checkOutput({tag, "_mem_r_data"}, mem_r_data, v.exp_rdata);
    checkOutput({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, v.exp_err});
    checkOutput({tag, "_aw_count"}, aw_cnt - aw0, v.wr ? 1 : 0);
    checkOutput({tag, "_w_count"}, w_cnt - w0, v.wr ? 1 : 0);
    checkOutput({tag, "_b_count"}, b_cnt - b0, v.wr ? 1 : 0);
    checkOutput({tag, "_ar_count"}, ar_cnt - ar0, v.wr ? 0 : 1);
    checkOutput({tag, "_r_count"}, r_cnt - r0, v.wr ? 0 : 1);
    if (v.wr) begin
      checkOutput({tag, "_awaddr"}, got_awaddr, v.exp_baddr);
      checkOutput({tag, "_wdata"}, got_wdata, v.data);
      checkOutput({tag, "_wstrb"}, {28'b0, got_wstrb}, {28'b0, v.strb});
      checkOutput({tag, "_w_held"}, hold_err - h0, 0);
      checkOutput({tag, "_bready_order"}, early_b - e0, 0);
    end else begin
      checkOutput({tag, "_araddr"}, got_araddr, v.exp_baddr);
    end
    if (v.exp_err) exp_pulses++;
    model_rdata = v.exp_rdata;
  endtask

  initial begin
    vec_t v;
    int   n, k;
    // Reset state, with a request held to confirm stall stays low.
    rst = 1; mem_r = 1; mem_w = 1; mem_addr = 32'h1234_5678;
    mem_w_data = 32'hFFFF_FFFF; mem_w_strb = 4'hF;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_resp = 0; cfg_rdata = 0; cfg_wdata = 0; cfg_wstrb = 0;
    model_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stall", {31'b0, stall}, 0);
    checkOutput("reset_valids", {27'b0, awvalid, wvalid, bready, arvalid, rready}, 0);
    checkOutput("reset_mem_r_data", mem_r_data, 0);
    checkOutput("reset_bus_err", {31'b0, bus_err}, 0);
    checkOutput("reset_awaddr", awaddr, 0);
    checkOutput("reset_wdata", wdata, 0);
    mem_r = 0; mem_w = 0;
    @(negedge clk); rst = 0;

    // Directed vectors, applied back to back.
    tbl[0] = mk(1, 0, 32'h0000_1006, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5_1234,
                3, 0, 32'hA5A5_1234, 32'h0000_1004);
    tbl[1] = mk(0, 1, 32'h0000_0020, 32'h0000_00FF, 4'b0001, 0, 4, 0, 0, 0, 2'b00, 32'h0,
                7, 0, 32'hA5A5_1234, 32'h0000_0020);
    tbl[2] = mk(0, 1, 32'h0000_0104, 32'h1122_3344, 4'hF, 0, 0, 4, 0, 0, 2'b00, 32'h0,
                7, 0, 32'hA5A5_1234, 32'h0000_0104);
    tbl[3] = mk(1, 0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'hDEAD_BEEF,
                3, 1, 32'hDEAD_BEEF, 32'h0000_0300);
    tbl[4] = mk(1, 0, 32'h0000_0047, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 32'h1234_5678,
                6, 0, 32'h1234_5678, 32'h0000_0044);
    tbl[5] = mk(0, 1, 32'h0000_0048, 32'h8765_4321, 4'hC, 3, 1, 0, 0, 0, 2'b00, 32'h0,
                6, 0, 32'h1234_5678, 32'h0000_0048);
    tbl[6] = mk(1, 1, 32'h0000_0052, 32'hCAFE_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h5555_AAAA,
                3, 0, 32'h1234_5678, 32'h0000_0050);
    tbl[7] = mk(0, 1, 32'h0000_0060, 32'h0, 4'b0011, 1, 1, 1, 0, 0, 2'b11, 32'h0,
                5, 1, 32'h1234_5678, 32'h0000_0060);
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("vec%0d", i), tbl[i]);

    // Randomized operations against the transaction-level model.
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 9);
      v.rd = (k <= 4) || (k == 9);
      v.wr = (k >= 5);
      v.addr = $urandom; v.data = $urandom;
      v.strb = 4'($urandom_range(1, 15));
      v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3);
      v.b_d = $urandom_range(0, 3); v.ar_d = $urandom_range(0, 3);
      v.r_d = $urandom_range(0, 3);
      v.resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
      v.slv_rdata = $urandom;
      v = modelExpect(v);
      applyStimulus($sformatf("rnd%0d", i), v);
    end

    // Asynchronous reset while waiting for read data.
    @(posedge clk); #1;
    cfg_ar_d = 0; cfg_r_d = 10; cfg_resp = 0; cfg_rdata = 32'h0BAD_F00D;
    mem_r = 1; mem_w = 0; mem_addr = 32'h0000_0080;
    n = 0;
    while (!rready && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("rst_reached_rd_data", {31'b0, rready}, 1);
    @(negedge clk); #2;
    rst = 1; #1;
    checkOutput("rst_rready_low", {31'b0, rready}, 0);
    checkOutput("rst_arvalid_low", {31'b0, arvalid}, 0);
    checkOutput("rst_stall_low", {31'b0, stall}, 0);
    checkOutput("rst_mem_r_data", mem_r_data, 0);
    mem_r = 0;
    @(negedge clk); rst = 0;
    model_rdata = 0;
    v = mk(1, 0, 32'h0000_0088, 32'h0, 4'h0, 1, 0, 0, 1, 2, 2'b00, 32'h7E57_0001,
           0, 0, 32'h0, 32'h0);
    v = modelExpect(v);
    applyStimulus("post_rst_read", v);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("bus_err_pulse_total", err_pulses, exp_pulses);
    checkOutput("idle_stall_low", {31'b0, stall}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
